// File: rtl/button_debounce_pkg.sv
// Shared types and helpers for the button debouncer.
package button_debounce_pkg;

   // Per-channel debounce state
   typedef enum logic [1:0] {
      RELEASED        = 2'd0,
      CONFIRM_PRESS   = 2'd1,
      PRESSED         = 2'd2,
      CONFIRM_RELEASE = 2'd3
   } db_state_e;

   // Width of the shared press counter (wraps modulo 256)
   localparam int PCNT_W = 8;

   // Bits needed to hold values 0..n-1, never less than 1
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/button_debounce_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM, debounce and
// long-press counters. Input is already normalised to active-high.
module debounce_chan #(
   parameter int DEBOUNCE_CYCLES = 2**16,
   parameter int LONG_CYCLES     = 2**23
) (
   input  logic clk,
   input  logic resetn,
   input  logic btn_i,
   output logic pressed_o,
   output logic press_pulse_o,
   output logic release_pulse_o,
   output logic long_pulse_o
);
   import button_debounce_pkg::*;

   localparam int DCNT_W = clog2(DEBOUNCE_CYCLES);
   localparam int LCNT_W = clog2(LONG_CYCLES + 1);
   // Transition fires on the cycle the counter steps onto DEBOUNCE_CYCLES-1
   localparam logic [DCNT_W-1:0] DB_LAST  = DCNT_W'(DEBOUNCE_CYCLES - 2);
   localparam logic [LCNT_W-1:0] LONG_MAX = LCNT_W'(LONG_CYCLES);
   localparam logic [LCNT_W-1:0] LONG_PRE = LCNT_W'(LONG_CYCLES - 1);

   logic              meta_q, meta_d;
   logic              sync_q, sync_d;
   db_state_e         state_q, state_d;
   logic [DCNT_W-1:0] dcnt_q, dcnt_d;
   logic [LCNT_W-1:0] lcnt_q, lcnt_d;
   logic              press_q, press_d;
   logic              rel_q, rel_d;
   logic              long_q, long_d;

   // Synchronizer shifts the pin in; both flops reset to the inactive level
   always_comb begin
      meta_d = btn_i;
      sync_d = meta_q;
   end

   // Next state, counters and registered strobes
   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      lcnt_d  = lcnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      long_d  = 1'b0;
      unique case (state_q)
         RELEASED: begin
            lcnt_d = '0;
            if (sync_q) begin
               state_d = CONFIRM_PRESS;
               dcnt_d  = '0;
            end
         end
         CONFIRM_PRESS: begin
            if (!sync_q) begin
               state_d = RELEASED;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
               if (dcnt_q == DB_LAST) begin
                  state_d = PRESSED;
                  press_d = 1'b1;
                  lcnt_d  = '0;
               end
            end
         end
         PRESSED: begin
            if (!sync_q) begin
               state_d = CONFIRM_RELEASE;
               dcnt_d  = '0;
            end
         end
         CONFIRM_RELEASE: begin
            if (sync_q) begin
               state_d = PRESSED;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
               if (dcnt_q == DB_LAST) begin
                  state_d = RELEASED;
                  rel_d   = 1'b1;
                  lcnt_d  = '0;
               end
            end
         end
         default: state_d = RELEASED;
      endcase
      // Hold timer runs through release bounces and saturates, so one long per press
      if ((state_q == PRESSED || state_q == CONFIRM_RELEASE) && state_d != RELEASED) begin
         if (lcnt_q != LONG_MAX) begin
            lcnt_d = lcnt_q + 1'b1;
            long_d = (lcnt_q == LONG_PRE);
         end
      end
   end

   // State registers; reset aborts any debounce or hold without a strobe
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         state_q <= RELEASED;
         dcnt_q  <= '0;
         lcnt_q  <= '0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         meta_q  <= meta_d;
         sync_q  <= sync_d;
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         lcnt_q  <= lcnt_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         long_q  <= long_d;
      end
   end

   assign pressed_o       = (state_q == PRESSED) || (state_q == CONFIRM_RELEASE);
   assign press_pulse_o   = press_q;
   assign release_pulse_o = rel_q;
   assign long_pulse_o    = long_q;

endmodule

// File: rtl/button_debounce.sv
// Multi-channel button debouncer: polarity normalisation, one debounce_chan
// per pin, and a shared wrap-around press counter.
module button_debounce #(
   parameter int NCH             = 3,
   parameter int DEBOUNCE_CYCLES = 2**16,
   parameter int LONG_CYCLES     = 2**23,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic [NCH-1:0] btn,
   output logic [NCH-1:0] pressed,
   output logic [NCH-1:0] press_pulse,
   output logic [NCH-1:0] release_pulse,
   output logic [NCH-1:0] long_pulse,
   output logic [7:0]     press_count
);
   import button_debounce_pkg::*;

   logic [NCH-1:0]    btn_norm;
   logic [PCNT_W-1:0] press_count_q, press_count_d;

   // Inversion only feeds the synchronizers; nothing else sees the raw pins
   assign btn_norm = (ACTIVE_LOW != 0) ? ~btn : btn;

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_chan (
         .clk             (clk),
         .resetn          (resetn),
         .btn_i           (btn_norm[g]),
         .pressed_o       (pressed[g]),
         .press_pulse_o   (press_pulse[g]),
         .release_pulse_o (release_pulse[g]),
         .long_pulse_o    (long_pulse[g])
      );
   end

   // Add every press strobe seen this cycle; simultaneous presses all count
   always_comb begin
      press_count_d = press_count_q;
      for (int i = 0; i < NCH; i++)
         press_count_d = press_count_d + PCNT_W'(press_pulse[i]);
   end

   // Press counter register, wraps naturally at 256
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) press_count_q <= '0;
      else         press_count_q <= press_count_d;
   end

   assign press_count = press_count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with NCH=3, DEBOUNCE_CYCLES=4,
// LONG_CYCLES=16, active-low pins.
module tb_button_debounce;

   logic       clk = 1'b0;
   logic       resetn;
   logic [2:0] btn;
   logic [2:0] pressed, press_pulse, release_pulse, long_pulse;
   logic [7:0] press_count;

   int checks = 0;
   int errors = 0;

   button_debounce #(
      .NCH             (3),
      .DEBOUNCE_CYCLES (4),
      .LONG_CYCLES     (16),
      .ACTIVE_LOW      (1)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .btn           (btn),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .press_count   (press_count)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".pressed"}, 32'(pressed), 32'd0);
      chk({tag, ".press_pulse"}, 32'(press_pulse), 32'd0);
      chk({tag, ".release_pulse"}, 32'(release_pulse), 32'd0);
      chk({tag, ".long_pulse"}, 32'(long_pulse), 32'd0);
      chk({tag, ".press_count"}, 32'(press_count), 32'd0);
   endtask

   initial begin
      resetn = 1'b0;
      btn    = 3'b111;
      step(3);
      chk_all_zero("reset");
      resetn = 1'b1;
      step(3);
      chk_all_zero("idle");

      // Single press on channel 0: pressed/press_pulse exactly 6 edges later
      btn[0] = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step(1);
         chk("p0.early_pressed", 32'(pressed), 32'd0);
         chk("p0.early_pulse", 32'(press_pulse), 32'd0);
      end
      step(1);
      chk("p0.pressed", 32'(pressed), 32'b001);
      chk("p0.press_pulse", 32'(press_pulse), 32'b001);
      step(1);
      chk("p0.pulse_width", 32'(press_pulse), 32'd0);
      chk("p0.held", 32'(pressed), 32'b001);
      chk("p0.count", 32'(press_count), 32'd1);
      btn[0] = 1'b1;
      step(5);
      chk("r0.early", 32'(release_pulse), 32'd0);
      chk("r0.still_pressed", 32'(pressed), 32'b001);
      step(1);
      chk("r0.release_pulse", 32'(release_pulse), 32'b001);
      chk("r0.pressed", 32'(pressed), 32'd0);
      step(2);

      // 3-cycle glitch on channel 1 must be ignored
      btn[1] = 1'b0;
      step(3);
      btn[1] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step(1);
         chk("glitch.pressed", 32'(pressed), 32'd0);
         chk("glitch.press_pulse", 32'(press_pulse), 32'd0);
         chk("glitch.release_pulse", 32'(release_pulse), 32'd0);
      end
      chk("glitch.count", 32'(press_count), 32'd1);

      // Long hold on channel 2: long_pulse once, 16 cycles after press_pulse
      btn[2] = 1'b0;
      step(6);
      chk("long.press_pulse", 32'(press_pulse), 32'b100);
      for (int k = 1; k <= 15; k++) begin
         step(1);
         chk("long.early", 32'(long_pulse), 32'd0);
      end
      step(1);
      chk("long.pulse", 32'(long_pulse), 32'b100);
      for (int k = 0; k < 18; k++) begin
         step(1);
         chk("long.once", 32'(long_pulse), 32'd0);
      end
      btn[2] = 1'b1;
      step(5);
      chk("long.rel_early", 32'(release_pulse), 32'd0);
      step(1);
      chk("long.release_pulse", 32'(release_pulse), 32'b100);
      chk("long.pressed", 32'(pressed), 32'd0);
      step(1);
      chk("long.count", 32'(press_count), 32'd2);

      // All three on the same edge
      btn = 3'b000;
      step(6);
      chk("tri.press_pulse", 32'(press_pulse), 32'b111);
      step(1);
      chk("tri.count", 32'(press_count), 32'd5);
      btn = 3'b111;
      step(6);
      chk("tri.release_pulse", 32'(release_pulse), 32'b111);
      step(2);

      // Reset the counter, then 86 triple presses: 255 after 85, wraps to 2
      resetn = 1'b0;
      #1;
      chk("wrap.reset_count", 32'(press_count), 32'd0);
      step(1);
      resetn = 1'b1;
      step(2);
      for (int n = 0; n < 86; n++) begin
         btn = 3'b000;
         step(8);
         btn = 3'b111;
         step(8);
         if (n == 84) chk("wrap.count_255", 32'(press_count), 32'd255);
      end
      chk("wrap.count_2", 32'(press_count), 32'd2);

      // Reset during CONFIRM_PRESS
      btn[0] = 1'b0;
      step(4);
      resetn = 1'b0;
      #1;
      chk_all_zero("rst_cp");
      step(2);
      chk_all_zero("rst_cp_hold");
      resetn = 1'b1;
      step(5);
      chk("rst_cp.early", 32'(pressed), 32'd0);
      step(1);
      chk("rst_cp.repress", 32'(pressed), 32'b001);
      chk("rst_cp.press_pulse", 32'(press_pulse), 32'b001);

      // Reset during PRESSED: drop immediately, no release strobe
      step(3);
      resetn = 1'b0;
      #1;
      chk_all_zero("rst_pr");
      step(2);
      resetn = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step(1);
         chk("rst_pr.no_release", 32'(release_pulse), 32'd0);
         chk("rst_pr.early", 32'(pressed), 32'd0);
      end
      step(1);
      chk("rst_pr.repress", 32'(pressed), 32'b001);
      chk("rst_pr.press_pulse", 32'(press_pulse), 32'b001);
      step(1);
      chk("rst_pr.count", 32'(press_count), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter NCH, default 3: number of independent button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 2**16: consecutive stable cycles required to accept a level change; legal range 2 to 2**24.
REQ-003 Parameter LONG_CYCLES, default 2**23: hold time in cycles before a long-press event; must exceed DEBOUNCE_CYCLES.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 means a pressed pin reads 0.
REQ-005 Port clk, input, 1 bit: single clock; all state is on the rising edge.
REQ-006 Port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port btn, input, NCH bits: raw asynchronous button pins.
REQ-008 Port pressed, output, NCH bits: debounced level, 1 while the button is held.
REQ-009 Port press_pulse, output, NCH bits: one-cycle strobe on an accepted press.
REQ-010 Port release_pulse, output, NCH bits: one-cycle strobe on an accepted release.
REQ-011 Port long_pulse, output, NCH bits: one-cycle strobe when a press reaches LONG_CYCLES.
REQ-012 Port press_count, output, 8 bits: total accepted presses across all channels.

Function
REQ-013 Each btn bit SHALL pass through a 2-flop synchronizer and then be normalised to active-high; raw pins drive no other logic.
REQ-014 Each channel SHALL run an FSM with states RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE.
REQ-015 RELEASED->CONFIRM_PRESS when the synced level is 1; the debounce counter clears on entry.
REQ-016 In CONFIRM_PRESS: synced 0 returns to RELEASED with no pulse; otherwise the counter increments and the FSM moves to PRESSED on the cycle the counter reaches DEBOUNCE_CYCLES-1.
REQ-017 PRESSED/CONFIRM_RELEASE SHALL mirror REQ-015/016 with the polarity inverted.
REQ-018 pressed SHALL be 1 in PRESSED and CONFIRM_RELEASE only.
REQ-019 A clean edge on btn SHALL appear on pressed exactly 2+DEBOUNCE_CYCLES clk edges later.
REQ-020 press_pulse/release_pulse SHALL be registered and assert in the same cycle that pressed changes.
REQ-021 Each channel SHALL count cycles from entry into PRESSED and SHALL assert long_pulse for one cycle when the count reaches LONG_CYCLES; at most one long_pulse per press; the count saturates and clears on return to RELEASED.
REQ-022 A glitch shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no change on pressed.
REQ-023 press_count SHALL add the number of press_pulse bits set in a cycle (0..NCH) and wrap modulo 256.
REQ-024 Simultaneous presses on several channels SHALL all be counted in the same cycle.
REQ-025 Channels SHALL be fully independent, sharing only press_count.

Reset
REQ-026 While resetn=0: synchronizer flops hold the inactive level, all FSMs are in RELEASED, all counters are 0, and all outputs are 0.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL abort with no pulse; after release, a held button is re-qualified from RELEASED.

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration, the counter-width function (clog2) and the press_count width constant (8).
REQ-029 One sub-module, debounce_chan, SHALL implement the synchronizer, FSM, debounce and long counters for one channel; it SHALL be instantiated NCH times by a generate loop.
REQ-030 The top level SHALL contain only the polarity normalisation, the instances and the press_count adder.

Verification (NCH=3, DEBOUNCE_CYCLES=4, LONG_CYCLES=16, ACTIVE_LOW=1)
REQ-031 Drive btn[0] from 1 to 0 and hold -> pressed[0] and press_pulse[0] rise exactly 6 edges later, press_pulse lasts 1 cycle, and press_count=1.
REQ-032 Pulse btn[1] low for 3 cycles -> no pulses, pressed[1] stays 0, and press_count is unchanged.
REQ-033 Hold btn[2] low for 40 cycles, then release -> long_pulse[2] fires once, 16 cycles after press_pulse[2]; release_pulse[2] fires 6 edges after the release.
REQ-034 Press all three channels on the same edge -> three press_pulse bits assert in one cycle and press_count increments by 3.
REQ-035 Perform 86 triple presses (258 presses) -> press_count wraps to 2.
REQ-036 Assert resetn=0 during CONFIRM_PRESS, then during PRESSED -> all outputs are 0 immediately, with no release_pulse; a still-held button re-presses 6 edges after resetn returns to 1.
